// File: rtl/cordic_vectoring.sv
// cordic_vectoring: iterative circular CORDIC, vectoring mode.
// Returns magnitude and atan2(y, x), angle scale 90 deg = 2^DSIZE.
// Define CORDIC_GAIN_COMP_EN to add a GAIN state that scales the
// magnitude by 1/K (one extra cycle and one constant multiplier).
module cordic_vectoring #(
    parameter int DSIZE = 16,
    parameter int ITER  = 16
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DSIZE-1:0] x_in,
    input  logic [DSIZE-1:0] y_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DSIZE+1:0] mag_out,
    output logic [DSIZE+1:0] ang_out
);

    localparam int W  = DSIZE + 2;
    localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;
    localparam int SR = (DSIZE < 30) ? 30 - DSIZE : 0;
    localparam int SL = (DSIZE > 30) ? DSIZE - 30 : 0;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ITER = 2'd1;
`ifdef CORDIC_GAIN_COMP_EN
    localparam logic [1:0] S_GAIN = 2'd2;
`endif
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [CW-1:0] LAST = CW'(ITER - 1);
    localparam logic [W-1:0]  Q90P = {2'b01, {DSIZE{1'b0}}};
    localparam logic [W-1:0]  Q90N = {2'b11, {DSIZE{1'b0}}};

    // atan(2^-i) with 360 deg = 2^32, i.e. 90 deg = 2^30.
    function automatic logic [31:0] atan_q30(input int i);
        logic [31:0] r;
        case (i)
            0:       r = 32'h2000_0000;
            1:       r = 32'h12E4_051E;
            2:       r = 32'h09FB_385B;
            3:       r = 32'h0511_11D4;
            4:       r = 32'h028B_0D43;
            5:       r = 32'h0145_D7E1;
            6:       r = 32'h00A2_F61E;
            7:       r = 32'h0051_7C55;
            8:       r = 32'h0028_BE53;
            9:       r = 32'h0014_5F2F;
            10:      r = 32'h000A_2F98;
            11:      r = 32'h0005_17CC;
            12:      r = 32'h0002_8BE6;
            13:      r = 32'h0001_45F3;
            14:      r = 32'h0000_A2FA;
            15:      r = 32'h0000_517D;
            16:      r = 32'h0000_28BE;
            17:      r = 32'h0000_145F;
            18:      r = 32'h0000_0A30;
            19:      r = 32'h0000_0518;
            20:      r = 32'h0000_028C;
            21:      r = 32'h0000_0146;
            22:      r = 32'h0000_00A3;
            23:      r = 32'h0000_0051;
            24:      r = 32'h0000_0029;
            25:      r = 32'h0000_0014;
            26:      r = 32'h0000_000A;
            27:      r = 32'h0000_0005;
            28:      r = 32'h0000_0003;
            29:      r = 32'h0000_0001;
            30:      r = 32'h0000_0001;
            default: r = 32'h0000_0000;
        endcase
        return r;
    endfunction

    // Rescale a 90 deg = 2^30 constant to 90 deg = 2^DSIZE, rounding.
    function automatic logic [63:0] scale_q30(input logic [63:0] v);
        logic [63:0] r;
        if (SR > 0)
            r = (v + (64'd1 << (SR - 1))) >> SR;
        else
            r = v << SL;
        return r;
    endfunction

    logic [W-1:0] atab [32];

    for (genvar k = 0; k < 32; k++) begin : g_atab
        assign atab[k] = W'(scale_q30(64'(atan_q30(k))));
    end

    logic [1:0]          state;
    logic [CW-1:0]       cnt;
    logic [4:0]          tidx;
    logic                zero;
    logic signed [W-1:0] x, y, z;
    logic signed [W-1:0] x_ext, y_ext;
    logic signed [W-1:0] x0, y0, z0;
    logic signed [W-1:0] x_sh, y_sh, a_cur;
    logic signed [W-1:0] x_nx, y_nx, z_nx;

    assign in_ready  = (state == S_IDLE) & ~rst;
    assign out_valid = (state == S_DONE);

    assign x_ext = {{2{x_in[DSIZE-1]}}, x_in};
    assign y_ext = {{2{y_in[DSIZE-1]}}, y_in};
    assign tidx  = 5'(cnt);

    // Fold the input pair into the right half-plane.
    always_comb begin
        x0 = x_ext;
        y0 = y_ext;
        z0 = '0;
        if (x_ext[W-1]) begin
            if (!y_ext[W-1]) begin
                x0 = y_ext;
                y0 = -x_ext;
                z0 = Q90P;
            end else begin
                x0 = -y_ext;
                y0 = x_ext;
                z0 = Q90N;
            end
        end
    end

    // One micro-rotation driving y towards zero.
    always_comb begin
        x_sh  = x >>> cnt;
        y_sh  = y >>> cnt;
        a_cur = $signed(atab[tidx]);
        if (!y[W-1]) begin
            x_nx = x + y_sh;
            y_nx = y - x_sh;
            z_nx = z + a_cur;
        end else begin
            x_nx = x - y_sh;
            y_nx = y + x_sh;
            z_nx = z - a_cur;
        end
    end

`ifdef CORDIC_GAIN_COMP_EN
    localparam int PW = W + DSIZE;
    localparam logic [DSIZE-1:0] KG =
        DSIZE'(scale_q30(64'd652032874));

    logic [W-1:0] mag_gain;

    assign mag_gain =
        W'((PW'($unsigned(x)) * PW'(KG)) >> DSIZE);
`endif

    // Control FSM, datapath registers and registered results.
    always_ff @(posedge clock) begin
        if (rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            zero    <= 1'b0;
            x       <= '0;
            y       <= '0;
            z       <= '0;
            mag_out <= '0;
            ang_out <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        x     <= x0;
                        y     <= y0;
                        z     <= z0;
                        zero  <= (x_in == '0) && (y_in == '0);
                        cnt   <= '0;
                        state <= S_ITER;
                    end
                end
                S_ITER: begin
                    x <= x_nx;
                    y <= y_nx;
                    z <= z_nx;
                    if (cnt == LAST) begin
                        cnt <= '0;
`ifdef CORDIC_GAIN_COMP_EN
                        state <= S_GAIN;
`else
                        state   <= S_DONE;
                        mag_out <= zero ? '0 : $unsigned(x_nx);
                        ang_out <= zero ? '0 : $unsigned(z_nx);
`endif
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`ifdef CORDIC_GAIN_COMP_EN
                S_GAIN: begin
                    state   <= S_DONE;
                    mag_out <= zero ? '0 : mag_gain;
                    ang_out <= zero ? '0 : $unsigned(z);
                end
`endif
                S_DONE: begin
                    if (out_ready)
                        state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_vectoring.sv
// tb_cordic_vectoring: directed and random checks of cordic_vectoring.
// Expected values come from integer and real-valued reference models.
`timescale 1ns/1ps
module tb_cordic_vectoring;

    localparam int DSIZE = 16;
    localparam int ITER  = 16;
    localparam int W     = DSIZE + 2;
`ifdef CORDIC_GAIN_COMP_EN
    localparam int LAT   = ITER + 1;
    localparam bit GC    = 1'b1;
`else
    localparam int LAT   = ITER;
    localparam bit GC    = 1'b0;
`endif
    localparam real PI   = 3.14159265358979;
    localparam longint MASK = (longint'(1) << W) - 1;

    logic             clock = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [DSIZE-1:0] x_in;
    logic [DSIZE-1:0] y_in;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     mag_out;
    logic [W-1:0]     ang_out;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int last_done;

    longint atab [32];
    longint kg;
    real    gain;

    cordic_vectoring #(.DSIZE(DSIZE), .ITER(ITER)) dut (
        .clock     (clock),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x_in      (x_in),
        .y_in      (y_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .mag_out   (mag_out),
        .ang_out   (ang_out)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input longint obs,
                         input longint exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic longint rnd(input real r);
        if (r >= 0.0) return longint'($rtoi(r + 0.5));
        return -longint'($rtoi(-r + 0.5));
    endfunction

    task automatic check_tol(input string tag, input longint obs,
                             input longint exp, input longint tol,
                             input bit wrap);
        longint d;
        bit     ok;
        d = obs - exp;
        if (wrap) begin
            d = d & MASK;
            if (d >= (longint'(1) << (W - 1)))
                d = d - (longint'(1) << W);
        end
        ok = (d <= tol) && (d >= -tol);
        n_assert++;
        assert (ok === 1'b1) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d +/- %0d",
                   tag, obs, exp, tol);
        end
    endtask

    // Algorithm-level model: fold, ITER shift-add steps, table angles.
    function automatic void ref_model(input int xi, input int yi,
                                      output longint mag,
                                      output longint ang);
        longint xr, yr, zr, xs, ys;
        if (xi == 0 && yi == 0) begin
            mag = 0;
            ang = 0;
            return;
        end
        if (xi >= 0) begin
            xr = xi; yr = yi; zr = 0;
        end else if (yi >= 0) begin
            xr = yi; yr = -xi; zr = longint'(1) << DSIZE;
        end else begin
            xr = -yi; yr = xi; zr = -(longint'(1) << DSIZE);
        end
        for (int i = 0; i < ITER; i++) begin
            xs = xr >>> i;
            ys = yr >>> i;
            if (yr >= 0) begin
                xr = xr + ys; yr = yr - xs; zr = zr + atab[i];
            end else begin
                xr = xr - ys; yr = yr + xs; zr = zr - atab[i];
            end
        end
        mag = GC ? ((xr * kg) >>> DSIZE) : xr;
        ang = zr & MASK;
    endfunction

    // Send one pair, wait for its result, check it, then accept it.
    task automatic run_pair(input int xv, input int yv,
                            input string tag, input bit ideal,
                            input bit b2b);
        longint em, ea, im, ia;
        real    rr;
        int     n;
        ref_model(xv, yv, em, ea);
        x_in      = DSIZE'(xv);
        y_in      = DSIZE'(yv);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            tick;
            n++;
        end
        check({tag, "_ready"}, longint'(in_ready), 1);
        tick;
        in_valid = 1'b0;
        x_in     = '0;
        y_in     = '0;
        n = 0;
        while (!out_valid && n < LAT + 20) begin
            tick;
            n++;
        end
        check({tag, "_lat"}, n, LAT);
        if (b2b)
            check({tag, "_thru"}, cyc - last_done, LAT + 2);
        last_done = cyc;
        check({tag, "_mag"}, longint'(mag_out), em);
        check({tag, "_ang"}, longint'(ang_out), ea);
        if (ideal) begin
            rr = $sqrt(real'(xv) * xv + real'(yv) * yv);
            im = rnd(rr * (GC ? 1.0 : gain));
            ia = rnd($atan2(real'(yv), real'(xv)) *
                     (2.0 ** (DSIZE + 1)) / PI);
            check_tol({tag, "_amag"}, longint'(mag_out), im,
                      GC ? 10 : 16, 1'b0);
            check_tol({tag, "_aang"}, longint'(ang_out), ia, 8, 1'b1);
        end
        tick;
    endtask

    initial begin
        int     xv, yv, n;
        bit     seen;
        longint em, ea;

        for (int i = 0; i < 32; i++)
            atab[i] = rnd($atan(2.0 ** (-i)) * (2.0 ** (DSIZE + 1)) / PI);
        kg   = rnd(0.6072529350 * (2.0 ** DSIZE));
        gain = 1.0;
        for (int i = 0; i < ITER; i++)
            gain = gain * $sqrt(1.0 + 2.0 ** (-2 * i));
        last_done = 0;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        x_in      = '0;
        y_in      = '0;
        tick;
        check("rst_in_ready", longint'(in_ready), 0);
        check("rst_out_valid", longint'(out_valid), 0);
        check("rst_mag", longint'(mag_out), 0);
        check("rst_ang", longint'(ang_out), 0);
        rst = 1'b0;
        #1;
        check("post_rst_ready", longint'(in_ready), 1);

        run_pair(1000, 0, "p1000_0", 1'b0, 1'b0);
        run_pair(0, 1000, "p0_1000", 1'b0, 1'b0);
        run_pair(1000, 1000, "p1000_1000", 1'b0, 1'b0);
        run_pair(-1000, 0, "pm1000_0", 1'b0, 1'b0);
        run_pair(-1000, -1000, "pm1000_m1000", 1'b0, 1'b0);
        run_pair(0, 0, "zero", 1'b0, 1'b0);
        check("zero_mag", longint'(mag_out), 0);
        check("zero_ang", longint'(ang_out), 0);
        run_pair(-32768, 32767, "corner_q2", 1'b1, 1'b0);
        run_pair(32767, -32768, "corner_q4", 1'b1, 1'b0);

        ref_model(3000, -4000, em, ea);
        x_in      = 16'(3000);
        y_in      = 16'(-4000);
        in_valid  = 1'b1;
        out_ready = 1'b0;
        tick;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < LAT + 20) begin
            tick;
            n++;
        end
        check("stall_lat", n, LAT);
        in_valid = 1'b1;
        x_in     = 16'(-7);
        y_in     = 16'(9);
        for (int k = 0; k < 5; k++) begin
            check("stall_valid", longint'(out_valid), 1);
            check("stall_ready", longint'(in_ready), 0);
            check("stall_mag", longint'(mag_out), em);
            check("stall_ang", longint'(ang_out), ea);
            tick;
        end
        out_ready = 1'b1;
        in_valid  = 1'b0;
        tick;
        check("release_ready", longint'(in_ready), 1);
        check("release_valid", longint'(out_valid), 0);
        seen = 1'b0;
        for (int k = 0; k < ITER + 4; k++) begin
            seen = seen | out_valid;
            tick;
        end
        check("ignored_pair", longint'(seen), 0);

        rst = 1'b1;
        #1;
        check("idle_rst_ready", longint'(in_ready), 0);
        tick;
        rst = 1'b0;

        x_in     = 16'(-20000);
        y_in     = 16'(12345);
        in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        for (int k = 0; k < 7; k++)
            tick;
        rst = 1'b1;
        #1;
        check("abort_rst_ready", longint'(in_ready), 0);
        tick;
        rst = 1'b0;
        #1;
        check("abort_valid", longint'(out_valid), 0);
        check("abort_mag", longint'(mag_out), 0);
        check("abort_ang", longint'(ang_out), 0);
        check("abort_ready", longint'(in_ready), 1);
        seen = 1'b0;
        for (int k = 0; k < ITER + 4; k++) begin
            seen = seen | out_valid;
            tick;
        end
        check("abort_no_result", longint'(seen), 0);
        run_pair(-32768, -32768, "min_min", 1'b1, 1'b0);
        check_tol("min_min_ang", longint'(ang_out), -98304, 8, 1'b1);

        for (int a = 0; a < 360; a++) begin
            xv = int'(rnd(30000.0 * $cos(real'(a) * PI / 180.0)));
            yv = int'(rnd(30000.0 * $sin(real'(a) * PI / 180.0)));
            run_pair(xv, yv, "sweep", 1'b1, a > 0);
        end

        for (int k = 0; k < 64; k++) begin
            xv = int'($urandom_range(65535)) - 32768;
            yv = int'($urandom_range(65535)) - 32768;
            if (k % 4 == 0) begin
                xv = int'($urandom_range(64)) - 32;
                yv = int'($urandom_range(64)) - 32;
            end
            run_pair(xv, yv, "random", 1'b0, k > 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/cordic_vectoring.md
# cordic_vectoring

Iterative circular CORDIC engine in vectoring mode. It takes a Cartesian pair (x, y) and returns its magnitude and its full-circle angle, atan2(y, x). It is the inverse of the rotation datapath: rotation consumes an angle and produces coordinates, and this block consumes coordinates and produces the angle. Angles use the datapath's existing angle format, so results feed the rotation path directly.

## Interface
- DSIZE, 16: input width; angle scale is 90° = 2^DSIZE.
- ITER, 16: number of micro-rotations; legal range 1..DSIZE.

- clock  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input pair is valid
- in_ready  out  1  block can accept a pair
- x_in  in  DSIZE  signed two's-complement x
- y_in  in  DSIZE  signed two's-complement y
- out_valid  out  1  result is valid
- out_ready  in  1  downstream accepts the result
- mag_out  out  DSIZE+2  unsigned magnitude
- ang_out  out  DSIZE+2  signed angle, 90° = 2^DSIZE

## Operation
- FSM has four states:
  - IDLE: in_ready=1. On in_valid, capture the pair and go to ITER.
  - ITER: run ITER micro-rotations, then go to GAIN if `CORDIC_GAIN_COMP_EN` is defined, else to DONE.
  - GAIN: present only with the macro; one cycle, then DONE.
  - DONE: out_valid=1. On out_ready, go to IDLE.
- Internal x and y registers are DSIZE+2 bits signed. The z register is DSIZE+2 bits signed and wraps modulo 2^(DSIZE+2).
- Pre-rotation at capture:
  - x_in ≥ 0: x=x_in, y=y_in, z=0.
  - x_in < 0 and y_in ≥ 0: x=y_in, y=−x_in, z=+2^DSIZE.
  - x_in < 0 and y_in < 0: x=−y_in, y=x_in, z=−2^DSIZE.
- Micro-rotation i (counter i = 0..ITER−1), where >>> is an arithmetic shift:
  - y ≥ 0: x+=y>>>i, y−=x>>>i, z+=A[i].
  - y < 0: x−=y>>>i, y+=x>>>i, z−=A[i].
  - All updates use the pre-iteration x and y values.
- Angle table: A[i] = atan(2^−i) in degrees × 2^DSIZE / 90, rounded to nearest. It is an internal constant table of 32 entries, so A[0] = 2^(DSIZE−1).
- Zero input: x_in = y_in = 0 sets a flag at capture, and the result is forced to mag_out=0, ang_out=0.
- Most-negative inputs (−2^(DSIZE−1)) must negate without overflow; the two guard bits cover this.
- An angle near ±180° may report either +2^(DSIZE+1)−δ or −2^(DSIZE+1)+δ; both are correct modulo 360°.
- mag_out and ang_out are registered and held stable while out_valid=1.

## Timing
- Reset values: in_ready=0 during the reset cycle and 1 in the first cycle after; out_valid=0, mag_out=0, ang_out=0; FSM goes to IDLE and the counter to 0.
- Accept is the edge where in_valid & in_ready. out_valid rises ITER cycles after the accept edge, or ITER+1 with the macro.
- in_ready is low from the accept edge until the edge after out_valid & out_ready. No overlap between operations.
- The result is held while out_ready=0, with no limit on the stall.
- Back-to-back throughput: one result per ITER+2 cycles, or ITER+3 with the macro.
- rst asserted in any state aborts the operation on that edge. The in-flight pair is discarded and no out_valid is produced for it.
- rst has priority over a simultaneous in_valid or out_ready.

## Configuration
- `CORDIC_GAIN_COMP_EN` defined:
  - GAIN state multiplies x by round(0.6072529350 × 2^DSIZE) and shifts right by DSIZE, so mag_out ≈ √(x²+y²).
  - Adds one cycle of latency.
- Macro undefined:
  - No GAIN state; mag_out is the raw final x, ≈ 1.6467602 × √(x²+y²).
  - No multiplier is synthesized.

## Test plan
All scenarios use DSIZE=16, ITER=16.
- (x,y)=(1000,0) -> ang_out=0±2, mag_out=1647±2 raw, or 1000±2 with the macro.
- (0,1000) -> ang_out=65536±2. (1000,1000) -> ang_out=32768±2, mag_out=1414±2 with the macro.
- (−1000,0) -> ang_out within 2 LSB of ±131072, mod 2^18. (−1000,−1000) -> ang_out=−98304±2. (0,0) -> mag_out=0, ang_out=0.
- Hold out_ready low for 5 cycles after out_valid -> outputs are stable, in_ready=0, and a new in_valid is ignored. Release -> in_ready=1 on the next cycle.
- Assert rst at iteration 7 -> out_valid stays 0, all outputs are 0, and in_ready=1 after reset. A new pair (−32768,−32768) then gives ang_out=−98304±2 with no overflow.
- Sweep 360 angles at radius 30000 against a reference model -> angle error ≤ 3 LSB, magnitude error ≤ 3 LSB with the macro.
